// File: rtl/goboard_runctl.sv
// goboard_runctl: CPU clock-enable run control (RUN/STEP/HALT), button debounce and paged hex display.
// STEP mode and its mode/step debouncers exist only when RUNCTL_STEP_EN is defined.
module goboard_runctl_db #(
    parameter int BITS = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic press_o
);
    logic [1:0]      sync_q;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic            lvl_q, press_q, flip;

    always_comb begin
        flip  = (sync_q[1] != lvl_q) && (&cnt_q);
        cnt_d = (sync_q[1] == lvl_q || flip) ? '0 : cnt_q + BITS'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_q ^ flip;
            press_q <= flip & ~lvl_q;
        end
    end

    assign press_o = press_q;
endmodule

module goboard_runctl #(
    parameter int DIV_BITS      = 19,
    parameter int DEBOUNCE_BITS = 16,
    parameter int VALUE_W       = 32,
    parameter int DIGITS        = 2,
    localparam int DW           = 4 * DIGITS,
    localparam int PAGES        = VALUE_W / DW,
    localparam int PW           = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_mode_i,
    input  logic               btn_step_i,
    input  logic               btn_page_i,
    input  logic               halt_i,
    input  logic [VALUE_W-1:0] value_i,
    output logic               clk_en_o,
    output logic [DW-1:0]      digits_o,
    output logic [PW-1:0]      page_o,
    output logic [1:0]         mode_o
);
    typedef enum logic [1:0] {RUN = 2'b00, STEP = 2'b01, HALT = 2'b10} state_t;

    state_t              state_q, state_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic                en_q, en_d;
    logic [PW-1:0]       page_q, page_d;
    logic [DW-1:0]       digits_q;
    logic                mode_p, step_p, page_p;

`ifdef RUNCTL_STEP_EN
    goboard_runctl_db #(.BITS(DEBOUNCE_BITS)) u_mode (.clk(clk), .reset_n(reset_n), .btn_i(btn_mode_i), .press_o(mode_p));
    goboard_runctl_db #(.BITS(DEBOUNCE_BITS)) u_step (.clk(clk), .reset_n(reset_n), .btn_i(btn_step_i), .press_o(step_p));
`else
    logic unused_btn;
    assign unused_btn = btn_mode_i ^ btn_step_i;
    assign mode_p     = 1'b0;
    assign step_p     = 1'b0;
`endif
    goboard_runctl_db #(.BITS(DEBOUNCE_BITS)) u_page (.clk(clk), .reset_n(reset_n), .btn_i(btn_page_i), .press_o(page_p));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        en_d    = 1'b0;
        case (state_q)
            RUN: begin
                div_d = div_q + DIV_BITS'(1);
                en_d  = &div_q;
                if (mode_p) begin
                    state_d = STEP;
                    div_d   = '0;
                end
            end
            STEP: begin
                div_d   = '0;
                state_d = mode_p ? RUN : STEP;
                en_d    = step_p & ~mode_p;
            end
            default: ;
        endcase
        // halt overrides any press and suppresses the enable in the same cycle
        if (halt_i) begin
            state_d = HALT;
            en_d    = 1'b0;
        end
        page_d = !page_p ? page_q : (page_q == PW'(PAGES - 1)) ? '0 : page_q + PW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            div_q    <= '0;
            en_q     <= 1'b0;
            page_q   <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            en_q     <= en_d;
            page_q   <= page_d;
            digits_q <= value_i[int'(page_q) * DW +: DW];
        end
    end

    assign clk_en_o = en_q;
    assign digits_o = digits_q;
    assign page_o   = page_q;
    assign mode_o   = 2'(state_q);
endmodule

// File: doc/goboard_runctl.md
# goboard_runctl

Parametrised run-control and display front-end for the Go Board CPU system, sitting between the board pins and `cpu_main` / `goboard_7seg`. Generates the CPU clock-enable in free-running RUN, single-STEP or HALT modes. Debounces the user buttons. Pages an arbitrary-width CPU value onto a configurable number of hex digits, so a full 32-bit DataAdr is viewable on the two on-board 7-segment displays.

## Interface

Parameters:
- `DIV_BITS`, default 19: RUN-mode enable period is 2^DIV_BITS clk cycles.
- `DEBOUNCE_BITS`, default 16: a button must be stable for 2^DEBOUNCE_BITS cycles to be accepted.
- `VALUE_W`, default 32: width of the displayed value.
  - Must be a multiple of 4*DIGITS.
- `DIGITS`, default 2: hex digits shown per page.
- Derived: PAGES = VALUE_W/(4*DIGITS); PW = max(1, $clog2(PAGES)).

Ports (clock and reset first):
- `clk` input 1: system clock, 12 MHz board clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `btn_mode_i` input 1: raw button, active-high when pressed. Toggles RUN/STEP.
- `btn_step_i` input 1: raw button, active-high. Issues one enable in STEP.
- `btn_page_i` input 1: raw button, active-high. Advances the display page.
- `halt_i` input 1: CPU halt request, synchronous to `clk`.
- `value_i` input VALUE_W: value to display.
- `clk_en_o` output 1: one-cycle CPU clock-enable pulse.
- `digits_o` output 4*DIGITS: currently selected nibbles. The most significant digit is in the top nibble.
- `page_o` output PW: current page index.
- `mode_o` output 2: 00 RUN, 01 STEP, 10 HALT.

## Operation

Reset:
- Asynchronous reset on `reset_n` low. All registers clear.
- State = RUN, divider = 0, page = 0, debounced levels = 0.
- All outputs at reset: `clk_en_o` = 0, `digits_o` = 0, `page_o` = 0, `mode_o` = 00.

Button conditioning (identical per button):
- 2-flop synchroniser, then a debounce counter.
- The counter clears whenever the synced input equals the debounced level. Otherwise it increments.
- At all-ones, the debounced level flips and the counter clears.
- A rising edge of the debounced level yields a one-cycle press pulse.
- Release generates no pulse.

Run-control state machine:
- RUN:
  - Divider increments every cycle.
  - `clk_en_o` = 1 for the cycle in which the divider is all-ones, then the divider wraps to 0.
  - Mode press: go to STEP; divider clears to 0.
- STEP:
  - Divider held at 0.
  - Step press: `clk_en_o` = 1 for exactly one cycle.
  - Mode press: go to RUN; divider restarts from 0.
- HALT:
  - Entered from RUN or STEP on the clock after `halt_i` = 1.
  - `clk_en_o` is forced 0 in any cycle where `halt_i` = 1 or state = HALT.
  - All button presses are ignored. HALT is left only by reset.
- Step press while in RUN: ignored.
- Simultaneous mode press and step press in STEP: the mode change wins; no enable is issued.
- `halt_i` together with any press: HALT wins.

Display pager:
- Page press increments the page; PAGES-1 wraps to 0.
- With PAGES = 1, the page stays 0.
- `digits_o` = `value_i[page*4*DIGITS +: 4*DIGITS]`, registered.
- Paging operates in every state, including HALT.

## Timing

- `clk_en_o` is registered.
- RUN:
  - First pulse 2^DIV_BITS cycles after reset release or after entering RUN.
  - Period 2^DIV_BITS cycles thereafter.
- STEP: `clk_en_o` is high in the cycle after the internal press pulse.
- Press pulse latency: 2 (synchroniser) + 2^DEBOUNCE_BITS + 1 cycles after the raw edge, assuming the input stays stable.
- Bounces shorter than 2^DEBOUNCE_BITS cycles produce no pulse.
- `digits_o` / `page_o`:
  - `digits_o` updates 1 cycle after a `value_i` change.
  - `page_o` updates in the cycle after the page press pulse.
  - `digits_o` shows the new page one cycle after `page_o` changes.
- `mode_o` changes the cycle after the causing press or `halt_i`.

## Configuration

- `RUNCTL_STEP_EN` defined:
  - Full RUN/STEP/HALT behaviour as above.
- `RUNCTL_STEP_EN` undefined:
  - STEP state, mode debouncer and step debouncer are compiled out.
  - `btn_mode_i` and `btn_step_i` are ignored.
  - The block is RUN until `halt_i`, then HALT.
  - `mode_o` never shows 01.

## Test plan

Bench parameters: DIV_BITS=4, DEBOUNCE_BITS=3, VALUE_W=32, DIGITS=2, `RUNCTL_STEP_EN` defined.

- Release reset, idle buttons -> `mode_o`=00, `clk_en_o` pulses at cycles 16, 32, 48 after release, each 1 cycle wide.
- Mode button held 20 cycles -> `mode_o`=01, no pulses. Step held 20 cycles -> exactly one `clk_en_o` pulse. Step glitch of 4 cycles -> no pulse.
- `value_i`=0x12345678; page presses 0-4 -> `digits_o` = 0x78, 0x56, 0x34, 0x12, 0x78 (wrap); `page_o` 0,1,2,3,0.
- `halt_i`=1 in the cycle where the divider is all-ones -> no `clk_en_o`; `mode_o`=10 next cycle; later mode and step presses -> no change, no pulses; page press still advances.
- Assert `reset_n`=0 asynchronously mid-RUN and mid-debounce -> all outputs 0 immediately. After release, the first pulse arrives exactly 16 cycles later.
- Rebuild without `RUNCTL_STEP_EN`; press mode and step -> `mode_o` stays 00, pulse period unchanged.
